// File: rtl/wcs_loader.sv
// wcs_loader: assembles 36-bit console chunks into microwords and writes them to the control store.
// Optional macro WCS_VERIFY_EN adds a read-back and compare of every written microword.
module wcs_loader #(
   parameter int cromWidth = 108,
   parameter int addrWidth = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ldSTART,
   input  logic [addrWidth-1:0] ldADDR,
   input  logic [addrWidth-1:0] ldCOUNT,
   input  logic                 ldABORT,
   input  logic [35:0]          ldDATA,
   input  logic                 ldVALID,
   output logic                 ldREADY,
   output logic                 ldBUSY,
   output logic                 ldDONE,
   output logic                 ldERR,
   output logic                 cpuHOLD,
   output logic [addrWidth-1:0] wcsADDR,
   output logic [0:cromWidth-1] wcsDATA,
   output logic                 wcsWE,
   input  logic [0:cromWidth-1] wcsRD
);
`ifdef WCS_VERIFY_EN
   typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, READ, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
   logic unusedRd;
   assign unusedRd = ^wcsRD;
`endif
   state_t state, nextState;
   logic [addrWidth-1:0] remaining;
   logic [1:0] chunkCnt;
   logic abort, take, advance, more;
   assign abort = ldABORT && state != IDLE;
   assign more = remaining > addrWidth'(1);
   assign ldBUSY = state != IDLE;
   assign cpuHOLD = state != IDLE;
   // abort masks every strobe in the same cycle it is seen
   assign ldREADY = state == COLLECT && !ldABORT;
   assign ldDONE = state == DONE && !ldABORT;
   assign wcsWE = state == WRITE && !ldABORT;
   assign take = ldREADY && ldVALID;
`ifdef WCS_VERIFY_EN
   assign advance = state == CHECK;
`else
   assign advance = state == WRITE;
`endif
   always_comb begin
      nextState = state;
      case (state)
         IDLE: nextState = ldSTART ? (ldCOUNT == '0 ? DONE : COLLECT) : IDLE;
         COLLECT: nextState = (take && chunkCnt == 2'd2) ? WRITE : COLLECT;
`ifdef WCS_VERIFY_EN
         WRITE: nextState = READ;
         READ: nextState = CHECK;
         CHECK: nextState = more ? COLLECT : DONE;
`else
         WRITE: nextState = more ? COLLECT : DONE;
`endif
         default: nextState = IDLE;
      endcase
      if (abort) nextState = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wcsADDR <= '0;
         wcsDATA <= '0;
         remaining <= '0;
         chunkCnt <= '0;
         ldERR <= 1'b0;
      end else begin
         state <= nextState;
         if (abort) begin
            ldERR <= 1'b1;
            chunkCnt <= '0;
         end else begin
            if (state == IDLE && ldSTART) begin
               wcsADDR <= ldADDR;
               remaining <= ldCOUNT;
               ldERR <= 1'b0;
               chunkCnt <= '0;
            end
            if (take) begin
               wcsDATA[36*chunkCnt +: 36] <= ldDATA;
               chunkCnt <= chunkCnt == 2'd2 ? 2'd0 : chunkCnt + 2'd1;
            end
            if (advance) begin
               remaining <= remaining - 1'b1;
               if (more) wcsADDR <= wcsADDR + 1'b1;
            end
`ifdef WCS_VERIFY_EN
            if (state == CHECK && wcsRD != wcsDATA) ldERR <= 1'b1;
`endif
         end
      end
   end
endmodule
